pipeline_pc_predict: RTL and testbench
======================================

Name: pipeline_pc_predict

Overview:
Parametrised fetch-stage PC unit for the pipelined MIPS core. It holds the PC and adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch predicts conditional branches. It redirects fetch on EX-stage mispredicts, ID-stage jumps, and exception vectors. It sits between the instruction memory address port and the ID/EX hazard logic, and replaces the fixed-width, non-predicting PC selector.

Parameters:
ADDR_W, 32, PC width; bit ADDR_W-1 is the kernel/supervisor bit.
BTB_DEPTH, 16, BTB entries; power of 2, minimum 2; IDX_W = log2(BTB_DEPTH).
RESET_VEC, 32'h8000_0000, PC after reset.
ILLOP_VEC, 32'h8000_0004, illegal-instruction vector.
XADR_VEC, 32'h8000_0008, interrupt/exception vector.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; 0 resets immediately.
pc_write  in  1  1 = fetch may advance; 0 = hazard stall.
exc_xadr  in  1  take the interrupt/exception vector.
exc_illop  in  1  take the illegal-instruction vector.
id_jump  in  1  ID stage resolved J/JAL/JR/JALR.
id_jump_target  in  ADDR_W  full jump target, formed upstream.
ex_valid  in  1  EX stage holds a valid conditional branch.
ex_pc  in  ADDR_W  PC of the EX branch.
ex_taken  in  1  actual branch outcome.
ex_target  in  ADDR_W  actual branch target (ConBA).
ex_pred_taken  in  1  prediction carried down the pipe with the branch.
ex_pred_target  in  ADDR_W  predicted target carried down the pipe.
pc  out  ADDR_W  current fetch PC.
pred_taken  out  1  prediction for the instruction at pc.
pred_target  out  ADDR_W  predicted target for the instruction at pc.
flush  out  1  1 = redirect this cycle; IF/ID and ID/EX must squash.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VEC; all BTB valid bits=0; counters=2'b00. pred_taken=0, pred_target=0, flush=0 while in reset and until the BTB hits.
- seq = {pc[ADDR_W-1], pc[ADDR_W-2:0]+4}. The kernel bit is preserved and the carry into it is dropped. ex_pc+4 uses the same rule.
- BTB entry: valid, tag = pc[ADDR_W-1:IDX_W+2], target (ADDR_W), ctr (2 bits). Index = pc[IDX_W+1:2].
- Lookup is combinational on pc. hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = hit ? entry target : 0.
- mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- Next-PC priority, highest first:
  1. exc_xadr -> XADR_VEC
  2. exc_illop -> ILLOP_VEC
  3. mispredict -> ex_taken ? ex_target : ex_pc+4
  4. id_jump -> id_jump_target
  5. pred_taken -> pred_target
  6. else -> seq
- Cases 1–3 update pc regardless of pc_write; flush=1 combinationally in the same cycle.
- Cases 4–6 update pc only when pc_write=1; otherwise pc holds. flush=0 for cases 4–6 (ID squashes its own delay slot).
- BTB update on every edge with ex_valid=1, independent of pc_write and of the redirect choice:
  - Hit at ex_pc: ctr increments on taken, saturating at 11; decrements on not-taken, saturating at 00. target <= ex_target when taken.
  - Miss and taken: allocate; overwrite valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not-taken: no change.
- Same-index lookup and update in one cycle: the lookup sees pre-update contents; the write is visible from the next cycle.
- Reset asserted mid-stall or mid-redirect: reset wins; all state returns to reset values.
- Latency: pc changes one edge after select; prediction is zero-cycle (combinational on pc).

Test Plan:
1. Release reset, pc_write=1, no events for 4 cycles -> pc = 80000000, 80000004, 80000008, 8000000C, 80000010; pred_taken=0; flush=0.
2. pc=8000FFFC, kernel-bit carry check -> next pc=80010000. pc=7FFFFFFC -> next pc=00000000, kernel bit stays 0.
3. Branch at 80000010, taken to 80000040, resolved in EX with ex_pred_taken=0 -> flush=1, pc<=80000040, entry ctr=10. Refetch 80000010 -> pred_taken=1, pred_target=80000040, next pc=80000040.
4. Same branch resolved not-taken twice -> first: mispredict, pc<=80000014, ctr 10->01. Next fetch of 80000010 -> pred_taken=0. Second: ctr 01->00 and holds at 00 on a third not-taken.
5. pc_write=0 with id_jump=1 -> pc holds. Same cycle exc_illop=1 -> pc<=80000004 and flush=1. exc_xadr and mispredict together -> pc<=80000008.
6. Aliasing: with BTB_DEPTH=16, branches at 80000010 and 80000050 share index 4 -> taken resolve of 80000050 replaces the tag. Fetch 80000010 -> pred_taken=0. Drop reset mid-run -> pc=80000000 and all predictions cleared.

Source files
------------

// File: rtl/pipeline_pc_predict_if.sv
// Fetch-side bundle between the PC/BTB unit and the pipeline control logic.
// The master drives stall, redirect and branch-resolution inputs; the slave returns pc, prediction and flush.
interface pipeline_pc_predict_if #(
   parameter int ADDR_W = 32
);
   logic              pc_write;
   logic              exc_xadr;
   logic              exc_illop;
   logic              id_jump;
   logic [ADDR_W-1:0] id_jump_target;
   logic              ex_valid;
   logic [ADDR_W-1:0] ex_pc;
   logic              ex_taken;
   logic [ADDR_W-1:0] ex_target;
   logic              ex_pred_taken;
   logic [ADDR_W-1:0] ex_pred_target;
   logic [ADDR_W-1:0] pc;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              flush;

   modport master (
      output pc_write, exc_xadr, exc_illop, id_jump, id_jump_target,
             ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
      input  pc, pred_taken, pred_target, flush
   );

   modport slave (
      input  pc_write, exc_xadr, exc_illop, id_jump, id_jump_target,
             ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
      output pc, pred_taken, pred_target, flush
   );
endinterface

// File: rtl/pipeline_pc_predict.sv
// Fetch-stage PC unit with a direct-mapped BTB of 2-bit saturating counters.
// Exceptions and EX mispredicts override stalls and raise flush; jumps and predictions obey pc_write.
module pipeline_pc_predict #(
   parameter int                ADDR_W    = 32,
   parameter int                BTB_DEPTH = 16,
   parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] ILLOP_VEC = 32'h8000_0004,
   parameter logic [ADDR_W-1:0] XADR_VEC  = 32'h8000_0008
) (
   input  logic                 clk,
   input  logic                 reset,
   pipeline_pc_predict_if.slave bus
);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [ADDR_W-2:0] STEP = {{(ADDR_W-4){1'b0}}, 3'b100};

   // The kernel bit never changes on a sequential step; the carry into it is discarded.
   function automatic logic [ADDR_W-1:0] add4(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1], a[ADDR_W-2:0] + STEP};
   endfunction

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              btb_valid_q  [BTB_DEPTH];
   logic              btb_valid_d  [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag_q    [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag_d    [BTB_DEPTH];
   logic [ADDR_W-1:0] btb_target_q [BTB_DEPTH];
   logic [ADDR_W-1:0] btb_target_d [BTB_DEPTH];
   logic [1:0]        btb_ctr_q    [BTB_DEPTH];
   logic [1:0]        btb_ctr_d    [BTB_DEPTH];

   logic [IDX_W-1:0]  f_idx_s, ex_idx_s;
   logic [TAG_W-1:0]  f_tag_s, ex_tag_s;
   logic              f_hit_s, ex_hit_s;
   logic              pred_taken_s, mispredict_s, redirect_s;
   logic [ADDR_W-1:0] pred_target_s;

   // Fetch lookup and EX-side index/hit, both purely combinational on registered contents.
   always_comb begin
      f_idx_s       = pc_q[IDX_W+1:2];
      f_tag_s       = pc_q[ADDR_W-1:IDX_W+2];
      ex_idx_s      = bus.ex_pc[IDX_W+1:2];
      ex_tag_s      = bus.ex_pc[ADDR_W-1:IDX_W+2];
      f_hit_s       = btb_valid_q[f_idx_s] && (btb_tag_q[f_idx_s] == f_tag_s);
      ex_hit_s      = btb_valid_q[ex_idx_s] && (btb_tag_q[ex_idx_s] == ex_tag_s);
      pred_taken_s  = f_hit_s && btb_ctr_q[f_idx_s][1];
      if (f_hit_s) begin
         pred_target_s = btb_target_q[f_idx_s];
      end else begin
         pred_target_s = {ADDR_W{1'b0}};
      end
      mispredict_s  = bus.ex_valid &&
                      ((bus.ex_taken != bus.ex_pred_taken) ||
                       (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
      redirect_s    = bus.exc_xadr || bus.exc_illop || mispredict_s;
   end

   // Next-PC selection; only the top three sources bypass a hazard stall.
   always_comb begin
      pc_d = pc_q;
      if (bus.exc_xadr) begin
         pc_d = XADR_VEC;
      end else if (bus.exc_illop) begin
         pc_d = ILLOP_VEC;
      end else if (mispredict_s) begin
         pc_d = bus.ex_taken ? bus.ex_target : add4(bus.ex_pc);
      end else if (!bus.pc_write) begin
         pc_d = pc_q;
      end else if (bus.id_jump) begin
         pc_d = bus.id_jump_target;
      end else if (pred_taken_s) begin
         pc_d = pred_target_s;
      end else begin
         pc_d = add4(pc_q);
      end
   end

   // BTB training from every resolved EX branch, regardless of stall or redirect.
   always_comb begin
      btb_valid_d  = btb_valid_q;
      btb_tag_d    = btb_tag_q;
      btb_target_d = btb_target_q;
      btb_ctr_d    = btb_ctr_q;
      if (bus.ex_valid && ex_hit_s) begin
         if (bus.ex_taken) begin
            btb_target_d[ex_idx_s] = bus.ex_target;
            if (btb_ctr_q[ex_idx_s] != 2'b11) begin
               btb_ctr_d[ex_idx_s] = btb_ctr_q[ex_idx_s] + 2'b01;
            end else begin
               btb_ctr_d[ex_idx_s] = 2'b11;
            end
         end else begin
            if (btb_ctr_q[ex_idx_s] != 2'b00) begin
               btb_ctr_d[ex_idx_s] = btb_ctr_q[ex_idx_s] - 2'b01;
            end else begin
               btb_ctr_d[ex_idx_s] = 2'b00;
            end
         end
      end else if (bus.ex_valid && bus.ex_taken) begin
         btb_valid_d[ex_idx_s]  = 1'b1;
         btb_tag_d[ex_idx_s]    = ex_tag_s;
         btb_target_d[ex_idx_s] = bus.ex_target;
         btb_ctr_d[ex_idx_s]    = 2'b10;
      end else begin
         btb_valid_d[ex_idx_s]  = btb_valid_q[ex_idx_s];
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= RESET_VEC;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_valid_q[i]  <= 1'b0;
            btb_tag_q[i]    <= {TAG_W{1'b0}};
            btb_target_q[i] <= {ADDR_W{1'b0}};
            btb_ctr_q[i]    <= 2'b00;
         end
      end else begin
         pc_q <= pc_d;
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_valid_q[i]  <= btb_valid_d[i];
            btb_tag_q[i]    <= btb_tag_d[i];
            btb_target_q[i] <= btb_target_d[i];
            btb_ctr_q[i]    <= btb_ctr_d[i];
         end
      end
   end

   assign bus.pc          = pc_q;
   assign bus.pred_taken  = pred_taken_s;
   assign bus.pred_target = pred_target_s;
   assign bus.flush       = reset && redirect_s;

endmodule

// File: tb/tb_pipeline_pc_predict.sv
// Bench for pipeline_pc_predict: a hand-derived vector table for the directed scenarios,
// a mid-run reset sequence, then random traffic against an arithmetic BTB/PC model.
module tb_pipeline_pc_predict;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   pipeline_pc_predict_if #(.ADDR_W(32)) bus ();

   pipeline_pc_predict #(.ADDR_W(32), .BTB_DEPTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pw, xadr, illop, jmp;
      logic [31:0] jt;
      logic        exv;
      logic [31:0] expc;
      logic        ext;
      logic [31:0] extgt;
      logic        expt;
      logic [31:0] exptgt;
      logic [31:0] e_pc;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_fl;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t row(logic pw, logic xadr, logic illop, logic jmp, logic [31:0] jt,
                                logic exv, logic [31:0] expc, logic ext, logic [31:0] extgt,
                                logic expt, logic [31:0] exptgt,
                                logic [31:0] e_pc, logic e_pt, logic [31:0] e_ptgt, logic e_fl);
      vec_t v;
      v.pw = pw; v.xadr = xadr; v.illop = illop; v.jmp = jmp; v.jt = jt;
      v.exv = exv; v.expc = expc; v.ext = ext; v.extgt = extgt;
      v.expt = expt; v.exptgt = exptgt;
      v.e_pc = e_pc; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_fl = e_fl;
      return v;
   endfunction

   function automatic vec_t idle(logic [31:0] e_pc, logic e_pt, logic [31:0] e_ptgt);
      return row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                 e_pc, e_pt, e_ptgt, 1'b0);
   endfunction

   function automatic vec_t jump(logic [31:0] jt, logic [31:0] e_pc);
      return row(1'b1, 1'b0, 1'b0, 1'b1, jt, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                 e_pc, 1'b0, 32'h0, 1'b0);
   endfunction

   function automatic vec_t exr(logic [31:0] expc, logic ext, logic [31:0] extgt, logic expt,
                                logic [31:0] exptgt, logic [31:0] e_pc, logic e_pt,
                                logic [31:0] e_ptgt, logic e_fl);
      return row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, expc, ext, extgt, expt, exptgt,
                 e_pc, e_pt, e_ptgt, e_fl);
   endfunction

   task automatic drive(input vec_t v);
      bus.pc_write = v.pw;   bus.exc_xadr = v.xadr; bus.exc_illop = v.illop;
      bus.id_jump = v.jmp;   bus.id_jump_target = v.jt;
      bus.ex_valid = v.exv;  bus.ex_pc = v.expc;    bus.ex_taken = v.ext;
      bus.ex_target = v.extgt; bus.ex_pred_taken = v.expt; bus.ex_pred_target = v.exptgt;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: BTB as plain arrays indexed by word address modulo depth.
   logic [31:0] m_pc;
   bit          m_v   [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ctr [16];
   logic [31:0] pool  [8];

   function automatic int idx_of(logic [31:0] a);
      return int'((a >> 2) % 32'd16);
   endfunction

   function automatic logic [31:0] seq_of(logic [31:0] a);
      return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
   endfunction

   task automatic model_reset();
      m_pc = 32'h8000_0000;
      for (int i = 0; i < 16; i++) begin
         m_v[i] = 1'b0; m_tag[i] = 32'h0; m_tgt[i] = 32'h0; m_ctr[i] = 0;
      end
   endtask

   initial begin
      vec_t        v;
      logic        hit, pt, mis, fl, ehit;
      logic [31:0] ptgt, npc;
      int          fi, ei;

      n_cmp = 0;
      n_err = 0;
      pool[0] = 32'h8000_0010; pool[1] = 32'h8000_0050; pool[2] = 32'h8000_0090;
      pool[3] = 32'h8000_0020; pool[4] = 32'h0000_0010; pool[5] = 32'h8000_0400;
      pool[6] = 32'h8000_003C; pool[7] = 32'h7FFF_FFFC;

      // Walk, BTB allocate/train/saturate, stall vs redirect, aliasing, kernel-bit carry.
      tbl.push_back(idle(32'h8000_0000, 1'b0, 32'h0));
      tbl.push_back(idle(32'h8000_0004, 1'b0, 32'h0));
      tbl.push_back(idle(32'h8000_0008, 1'b0, 32'h0));
      tbl.push_back(idle(32'h8000_000C, 1'b0, 32'h0));
      tbl.push_back(idle(32'h8000_0010, 1'b0, 32'h0));
      tbl.push_back(exr(32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 32'h8000_0014, 1'b0, 32'h0, 1'b1));
      tbl.push_back(jump(32'h8000_0010, 32'h8000_0040));
      tbl.push_back(idle(32'h8000_0010, 1'b1, 32'h8000_0040));
      tbl.push_back(exr(32'h8000_0010, 1'b0, 32'h0, 1'b1, 32'h8000_0040, 32'h8000_0040, 1'b0, 32'h0, 1'b1));
      tbl.push_back(jump(32'h8000_0010, 32'h8000_0014));
      tbl.push_back(exr(32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8000_0010, 1'b0, 32'h8000_0040, 1'b0));
      tbl.push_back(exr(32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8000_0014, 1'b0, 32'h0, 1'b0));
      tbl.push_back(exr(32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 32'h8000_0018, 1'b0, 32'h0, 1'b1));
      tbl.push_back(jump(32'h8000_0010, 32'h8000_0040));
      tbl.push_back(exr(32'h8000_0010, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 32'h8000_0010, 1'b0, 32'h8000_0040, 1'b1));
      tbl.push_back(row(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                        32'h8000_0040, 1'b0, 32'h0, 1'b0));
      tbl.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                        32'h8000_0040, 1'b0, 32'h0, 1'b1));
      tbl.push_back(row(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0040,
                        1'b1, 32'h8000_0044, 32'h8000_0004, 1'b0, 32'h0, 1'b1));
      tbl.push_back(row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                        32'h8000_0008, 1'b0, 32'h0, 1'b0));
      tbl.push_back(jump(32'h8000_0010, 32'h8000_0008));
      tbl.push_back(idle(32'h8000_0010, 1'b1, 32'h8000_0040));
      tbl.push_back(exr(32'h8000_0050, 1'b1, 32'h8000_0090, 1'b0, 32'h0, 32'h8000_0040, 1'b0, 32'h0, 1'b1));
      tbl.push_back(jump(32'h8000_0010, 32'h8000_0090));
      tbl.push_back(idle(32'h8000_0010, 1'b0, 32'h0));
      tbl.push_back(jump(32'h8000_0050, 32'h8000_0014));
      tbl.push_back(idle(32'h8000_0050, 1'b1, 32'h8000_0090));
      tbl.push_back(jump(32'h8000_FFFC, 32'h8000_0090));
      tbl.push_back(idle(32'h8000_FFFC, 1'b0, 32'h0));
      tbl.push_back(jump(32'h7FFF_FFFC, 32'h8001_0000));
      tbl.push_back(idle(32'h7FFF_FFFC, 1'b0, 32'h0));
      tbl.push_back(exr(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0000, 1'b0, 32'h0, 1'b1));
      tbl.push_back(idle(32'h8000_0000, 1'b0, 32'h0));
      tbl.push_back(idle(32'h8000_0004, 1'b0, 32'h0));

      // Reset with redirect requests pending: flush and prediction must stay low.
      reset = 1'b0;
      drive(row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                32'h0, 1'b0, 32'h0, 1'b0));
      repeat (3) @(posedge clk);
      #5;
      chk("reset pc", bus.pc, 32'h8000_0000);
      chk("reset flush", {31'h0, bus.flush}, 32'h0);
      chk("reset pred_taken", {31'h0, bus.pred_taken}, 32'h0);
      chk("reset pred_target", bus.pred_target, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i]);
         #4;
         chk($sformatf("row%0d pc", i), bus.pc, tbl[i].e_pc);
         chk($sformatf("row%0d pred_taken", i), {31'h0, bus.pred_taken}, {31'h0, tbl[i].e_pt});
         chk($sformatf("row%0d pred_target", i), bus.pred_target, tbl[i].e_ptgt);
         chk($sformatf("row%0d flush", i), {31'h0, bus.flush}, {31'h0, tbl[i].e_fl});
         @(posedge clk);
         #1;
      end

      // Reset dropped mid-redirect while stalled: clears pc and trained entries at once.
      drive(row(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0040,
                1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
      #1;
      reset = 1'b0;
      #1;
      chk("midreset pc", bus.pc, 32'h8000_0000);
      chk("midreset flush", {31'h0, bus.flush}, 32'h0);
      @(posedge clk);
      #1;
      chk("midreset hold pc", bus.pc, 32'h8000_0000);
      reset = 1'b1;
      drive(jump(32'h8000_0050, 32'h0));
      #4;
      chk("postreset flush", {31'h0, bus.flush}, 32'h0);
      @(posedge clk);
      #1;
      drive(idle(32'h0, 1'b0, 32'h0));
      chk("postreset pc", bus.pc, 32'h8000_0050);
      chk("postreset pred_taken", {31'h0, bus.pred_taken}, 32'h0);
      chk("postreset pred_target", bus.pred_target, 32'h0);

      // Random traffic against the model.
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         v.pw     = ($urandom_range(0, 3) != 0);
         v.xadr   = ($urandom_range(0, 39) == 0);
         v.illop  = ($urandom_range(0, 39) == 0);
         v.jmp    = ($urandom_range(0, 4) == 0);
         v.jt     = pool[$urandom_range(0, 7)];
         v.exv    = $urandom_range(0, 1);
         v.expc   = pool[$urandom_range(0, 7)];
         v.ext    = $urandom_range(0, 1);
         v.extgt  = pool[$urandom_range(0, 7)];
         v.expt   = $urandom_range(0, 1);
         v.exptgt = ($urandom_range(0, 1) != 0) ? v.extgt : pool[$urandom_range(0, 7)];
         drive(v);

         fi   = idx_of(m_pc);
         hit  = m_v[fi] && (m_tag[fi] == (m_pc >> 6));
         pt   = hit && (m_ctr[fi] >= 2);
         ptgt = hit ? m_tgt[fi] : 32'h0;
         mis  = v.exv && ((v.ext != v.expt) || (v.ext && (v.extgt != v.exptgt)));
         fl   = v.xadr || v.illop || mis;
         if (v.xadr)          npc = 32'h8000_0008;
         else if (v.illop)    npc = 32'h8000_0004;
         else if (mis)        npc = v.ext ? v.extgt : seq_of(v.expc);
         else if (!v.pw)      npc = m_pc;
         else if (v.jmp)      npc = v.jt;
         else if (pt)         npc = ptgt;
         else                 npc = seq_of(m_pc);

         #4;
         chk($sformatf("rnd%0d pc", c), bus.pc, m_pc);
         chk($sformatf("rnd%0d pred_taken", c), {31'h0, bus.pred_taken}, {31'h0, pt});
         chk($sformatf("rnd%0d pred_target", c), bus.pred_target, ptgt);
         chk($sformatf("rnd%0d flush", c), {31'h0, bus.flush}, {31'h0, fl});

         if (v.exv) begin
            ei   = idx_of(v.expc);
            ehit = m_v[ei] && (m_tag[ei] == (v.expc >> 6));
            if (ehit && v.ext) begin
               m_ctr[ei] = (m_ctr[ei] < 3) ? m_ctr[ei] + 1 : 3;
               m_tgt[ei] = v.extgt;
            end else if (ehit) begin
               m_ctr[ei] = (m_ctr[ei] > 0) ? m_ctr[ei] - 1 : 0;
            end else if (v.ext) begin
               m_v[ei] = 1'b1; m_tag[ei] = v.expc >> 6; m_tgt[ei] = v.extgt; m_ctr[ei] = 2;
            end
         end
         m_pc = npc;
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
